// File: rtl/collision_scanner.sv
// collision_scanner
//   Time-multiplexed frog/car collision engine. A frame_tick snapshots the
//   frog position, then one car slot is box-tested per clock. One registered
//   death or win pulse is produced per scan, together with the lowest hit
//   slot. A death is followed by a grace period of GRACE_FRAMES ticks during
//   which no scans are started.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for frame_tick
//   SCAN   | testing slot idx against the frog snapshot, one slot per cycle
//   REPORT | death_pulse / win_pulse valid for this one cycle
//   HOLD   | grace period after a death, counting frame_ticks down
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_tick        one-cycle scan request
//   frog_x, frog_y    frog top-left corner
//   car_x, car_y      packed car corners, slot i at [i*COORD_W +: COORD_W]
//   car_enable        per-slot enable; a 0 slot never hits
//   death_pulse       one-cycle pulse: an enabled car overlapped the frog
//   win_pulse         one-cycle pulse: frog snapshot y == 0 and no hit
//   hit_index         lowest hit slot of the last scan that reported a death
//   busy              high in SCAN, REPORT and HOLD
//   overrun           one-cycle pulse: frame_tick dropped in SCAN/REPORT
module collision_scanner #(
  parameter int NUM_CARS     = 8,
  parameter int COORD_W      = 10,
  parameter int TILE_SIZE    = 32,
  parameter int GRACE_FRAMES = 2,
  parameter int IDX_W        = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic [COORD_W-1:0]          frog_x,
  input  logic [COORD_W-1:0]          frog_y,
  input  logic [NUM_CARS*COORD_W-1:0] car_x,
  input  logic [NUM_CARS*COORD_W-1:0] car_y,
  input  logic [NUM_CARS-1:0]         car_enable,
  output logic                        death_pulse,
  output logic                        win_pulse,
  output logic [IDX_W-1:0]            hit_index,
  output logic                        busy,
  output logic                        overrun
);

  localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [COORD_W:0]   TILE       = (COORD_W + 1)'(TILE_SIZE);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CARS - 1);
  localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_FRAMES);
  localparam logic [GRACE_W-1:0] GRACE_ONE  = GRACE_W'(1);
  localparam logic               GRACE_EN   = (GRACE_FRAMES > 0);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT, S_HOLD} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [GRACE_W-1:0]   grace_cnt;
  logic                 hit;
  logic [IDX_W-1:0]     hit_slot;
  logic [COORD_W-1:0]   snap_x;
  logic [COORD_W-1:0]   snap_y;

  // Slot selected by idx; cars are read live while scanning.
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               cur_en;

  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    cur_en = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_x  = car_x[i*COORD_W +: COORD_W];
        cur_y  = car_y[i*COORD_W +: COORD_W];
        cur_en = car_enable[i];
      end
    end
  end

  // One extra bit so corner + TILE never wraps near the top of the range.
  logic [COORD_W:0] fx_w, fy_w, cx_w, cy_w;
  logic             overlap;
  logic             hit_now;
  logic [IDX_W-1:0] slot_now;

  assign fx_w = {1'b0, snap_x};
  assign fy_w = {1'b0, snap_y};
  assign cx_w = {1'b0, cur_x};
  assign cy_w = {1'b0, cur_y};

  // Strict compares: boxes that only share an edge do not collide.
  assign overlap = cur_en
                   && (fx_w < cx_w + TILE) && (cx_w < fx_w + TILE)
                   && (fy_w < cy_w + TILE) && (cy_w < fy_w + TILE);

  // Result including the slot being tested in the final SCAN cycle.
  assign hit_now  = hit | overlap;
  assign slot_now = hit ? hit_slot : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      grace_cnt   <= '0;
      hit         <= 1'b0;
      hit_slot    <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      death_pulse <= 1'b0;
      win_pulse   <= 1'b0;
      hit_index   <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      death_pulse <= 1'b0;
      win_pulse   <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            snap_x <= frog_x;
            snap_y <= frog_y;
            hit    <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (frame_tick) overrun <= 1'b1;
          if (overlap && !hit) begin
            hit      <= 1'b1;
            hit_slot <= idx;
          end
          if (idx == LAST_IDX) begin
            // Pulses are launched here so they are valid during REPORT.
            state <= S_REPORT;
            if (hit_now) begin
              death_pulse <= 1'b1;
              hit_index   <= slot_now;
            end else if (snap_y == '0) begin
              win_pulse <= 1'b1;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_REPORT: begin
          if (frame_tick) overrun <= 1'b1;
          if (hit && GRACE_EN) begin
            grace_cnt <= GRACE_LOAD;
            state     <= S_HOLD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (frame_tick) begin
            if (grace_cnt == GRACE_ONE) begin
              grace_cnt <= '0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              grace_cnt <= grace_cnt - GRACE_ONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/collision_scanner.md
# collision_scanner

Time-multiplexed, parametrised collision engine for the frog game. Once per frame it snapshots the frog position, then walks every car slot, one per clock, with an axis-aligned bounding-box test. It reports a single registered death or win pulse plus the index of the lowest-numbered car that was hit. After a death it applies a frame-counted grace period that suppresses further scans. It sits between the object position logic and the game-state controller, and replaces the per-car combinational overlap tree.

## Interface
- NUM_CARS, 8: number of car slots scanned; must be ≥1.
- COORD_W, 10: width of every x/y coordinate.
- TILE_SIZE, 32: edge length of both frog and car boxes, in pixels.
- GRACE_FRAMES, 2: number of frame_tick pulses ignored after a death; 0 disables the grace period.
- IDX_W, $clog2(NUM_CARS) (minimum 1): width of hit_index.

Ports (clock and reset first):
- clk  in  1: the single clock.
- rst_n  in  1: asynchronous, active-low reset.
- frame_tick  in  1: one-cycle pulse that starts a scan.
- frog_x, frog_y  in  COORD_W each: frog top-left corner.
- car_x, car_y  in  NUM_CARS*COORD_W each: packed buses; slot i occupies bits [i*COORD_W +: COORD_W].
- car_enable  in  NUM_CARS: per-slot enable mask; a 0 bit means the slot never hits. Driven by the level logic.
- death_pulse  out  1: one-cycle pulse, at least one enabled car overlapped the frog.
- win_pulse  out  1: one-cycle pulse, frog snapshot y == 0 and no hit.
- hit_index  out  IDX_W: lowest hit slot from the last scan that reported a death.
- busy  out  1: high in SCAN, REPORT or HOLD.
- overrun  out  1: one-cycle pulse when frame_tick arrives during SCAN or REPORT.

## Operation
- FSM states: IDLE, SCAN, REPORT, HOLD.
- IDLE, with frame_tick = 1:
  - Snapshot frog_x/frog_y into internal registers.
  - Clear the hit flag, set idx = 0, go to SCAN.
- SCAN tests slot idx each cycle:
  - Overlap = car_enable[idx] && (fx < cx+T) && (cx < fx+T) && (fy < cy+T) && (cy < fy+T), where fx/fy are the snapshot and T = TILE_SIZE.
  - All sums are computed at COORD_W+1 bits, so nothing wraps; coordinates near 2^COORD_W−1 compare correctly.
  - Edge-touching boxes (cx == fx+T) do not overlap.
  - On the first overlap, set the hit flag and record idx; later hits do not overwrite it, so the lowest index wins.
  - Car buses and car_enable are sampled live. The producer holds them stable from frame_tick until busy falls or the FSM enters HOLD.
  - When idx == NUM_CARS−1, go to REPORT. Otherwise increment idx.
- REPORT (one cycle):
  - If hit: death_pulse = 1 and hit_index is updated. Go to HOLD if GRACE_FRAMES > 0, loading grace_cnt = GRACE_FRAMES; otherwise go to IDLE.
  - Else if snapshot fy == 0: win_pulse = 1, go to IDLE.
  - Else: go to IDLE. No pulse.
  - Death has priority over win; the two pulses are never high together.
- HOLD:
  - Each frame_tick decrements grace_cnt.
  - The tick that takes grace_cnt from 1 to 0 returns the FSM to IDLE and does not start a scan.
  - overrun is not raised in HOLD.
- frame_tick during SCAN or REPORT is dropped and overrun pulses for one cycle. The scan in progress is not disturbed.
- hit_index holds its value until the next death report.

## Timing
- frame_tick is sampled at edge k. SCAN occupies cycles k+1 … k+NUM_CARS.
- REPORT is at cycle k+NUM_CARS+1. death_pulse/win_pulse and hit_index are registered and valid in that cycle.
- Latency from tick to result: NUM_CARS+1 cycles. Minimum tick spacing without overrun: NUM_CARS+2 cycles.
- busy rises in cycle k+1. It falls in the cycle after REPORT, or when HOLD exits.
- Reset (asynchronous, any state, including mid-scan):
  - FSM returns to IDLE.
  - idx, grace_cnt, hit flag, snapshot and hit_index are cleared to 0.
  - All outputs go to 0.
  - No pulse is emitted for the aborted scan.

## Test plan
- NUM_CARS=8, car 3 at (100,200) enabled, frog (120,210), tick at cycle 0 → death_pulse in cycle 9 only, hit_index=3, win_pulse=0.
- Cars 2 and 5 both overlap the frog → hit_index=2. Same stimulus with car_enable[2]=0 → hit_index=5.
- Frog (0,0), no overlap → win_pulse in cycle 9. Frog (0,0) with car 0 at (10,0) → death_pulse only.
- Adjacency and wrap: car at (1000,500), frog (968,500) → no hit (edge touch). Frog (969,500) → hit, with no wrap error.
- Grace: GRACE_FRAMES=2, death, then ticks 1 and 2 → no scan and busy stays high. Tick 3 → new scan starts. A tick at cycle 4 of a scan → overrun pulse and the result is unchanged.
- Assert rst_n low at cycle 5 of a hit scan → all outputs 0 immediately, no death_pulse. After release, the next tick scans normally.
